// File: rtl/acia_host_pkg.sv
// rtl/acia_host_pkg.sv - shared FSM encoding, ACIA register bit indices and strobe decode
package acia_host_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_POLL = 3'd1,
    ST_RXRD = 3'd2,
    ST_TXWR = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  localparam int STAT_TDRE = 7;
  localparam int STAT_RDRF = 6;
  localparam int CTRL_RXIE = 7;
  localparam int CTRL_TXIE = 6;

  typedef struct packed {
    logic rs;
    logic rd;
    logic we;
    logic en;
  } bus_t;

  // Bus cycle performed while the FSM sits in a given state.
  function automatic bus_t bus_decode(input state_t s);
    bus_t b;
    b = '0;
    case (s)
      ST_INIT: b.we = 1'b1;
      ST_POLL: b.rd = 1'b1;
      ST_RXRD: begin
        b.rs = 1'b1;
        b.rd = 1'b1;
      end
      ST_TXWR: begin
        b.rs = 1'b1;
        b.we = 1'b1;
        b.en = 1'b1;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ctrl_byte(input logic rx_ie, input logic tx_ie);
    logic [7:0] c;
    c = '0;
    c[CTRL_RXIE] = rx_ie;
    c[CTRL_TXIE] = tx_ie;
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with occupancy output
module sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acia_host.sv
// rtl/acia_host.sv - bus master for one MC6850-style ACIA with TX/RX byte FIFOs
module acia_host
  import acia_host_pkg::*;
#(
  parameter int         TX_DEPTH  = 8,
  parameter int         RX_DEPTH  = 8,
  parameter logic [7:0] CTRL_INIT = 8'h00
) (
  input  logic                        clk,
  input  logic                        sys_rst_n,
  input  logic                        tx_valid,
  input  logic [7:0]                  tx_byte,
  output logic                        tx_ready,
  output logic                        rx_valid,
  output logic [7:0]                  rx_byte,
  input  logic                        rx_ready,
  output logic                        uart_cs,
  output logic                        uart_rs,
  output logic                        uart_en,
  output logic                        rd_pin,
  output logic                        we_pin,
  output logic [7:0]                  mem_wdata,
  input  logic [7:0]                  mem_rdata,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);

  localparam int RXLW = $clog2(RX_DEPTH) + 1;

  state_t     state;
  state_t     next_state;
  logic       started;
  bus_t       bus_d;
  logic [7:0] wdata_d;

  logic       tx_full;
  logic       tx_empty;
  logic [7:0] tx_head;
  logic       tx_pop;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_push;
  logic       rx_pop_ok;
  logic       rx_full_next;

  sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .push      (tx_valid),
    .wdata     (tx_byte),
    .pop       (tx_pop),
    .rdata     (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .push      (rx_push),
    .wdata     (mem_rdata),
    .pop       (rx_ready),
    .rdata     (rx_byte),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign tx_pop    = (state == ST_TXWR);
  assign rx_push   = (state == ST_RXRD);
  assign rx_pop_ok = rx_ready && !rx_empty;

  // RX occupancy after this edge; a status read with RX full would lose RDRF.
  assign rx_full_next = rx_push ? ((rx_level == RXLW'(RX_DEPTH - 1)) && !rx_pop_ok)
                                : (rx_full && !rx_pop_ok);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_INIT;
      started   <= 1'b0;
      uart_cs   <= 1'b0;
      uart_rs   <= 1'b0;
      uart_en   <= 1'b0;
      rd_pin    <= 1'b0;
      we_pin    <= 1'b0;
      mem_wdata <= 8'h00;
    end else begin
      state     <= next_state;
      started   <= 1'b1;
      uart_cs   <= 1'b1;
      uart_rs   <= bus_d.rs;
      uart_en   <= bus_d.en;
      rd_pin    <= bus_d.rd;
      we_pin    <= bus_d.we;
      mem_wdata <= wdata_d;
    end
  end

  // The first edge after release re-enters INIT so its strobes come from flops.
  always_comb begin
    next_state = state;
    if (!started) begin
      next_state = ST_INIT;
    end else begin
      case (state)
        ST_POLL: begin
          if (mem_rdata[STAT_RDRF])
            next_state = ST_RXRD;
          else if (mem_rdata[STAT_TDRE] && !tx_empty)
            next_state = ST_TXWR;
          else
            next_state = ST_POLL;
        end
        default: next_state = rx_full_next ? ST_HOLD : ST_POLL;
      endcase
    end
  end

  // TX head is stable from the deciding POLL until the TXWR pop.
  always_comb begin
    bus_d   = bus_decode(next_state);
    wdata_d = 8'h00;
    if (next_state == ST_INIT)
      wdata_d = CTRL_INIT;
    else if (next_state == ST_TXWR)
      wdata_d = tx_head;
  end

endmodule

// File: tb/tb_acia_host.sv
// tb/tb_acia_host.sv - directed and randomized bench for acia_host against an ACIA model
module tb_acia_host;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       uart_cs;
  logic       uart_rs;
  logic       uart_en;
  logic       rd_pin;
  logic       we_pin;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [3:0] tx_level;
  logic [3:0] rx_level;

  int checks = 0;
  int errors = 0;

  // ACIA device state and host-visible byte queues
  logic       tdre;
  logic       rdrf;
  logic [7:0] rdr;
  bit         auto_tdre;
  bit         auto_rx;
  int         tdre_wait;
  int         tdre_max;
  int         rel_cycles;
  int         n_wr;
  int         n_pop;
  logic [7:0] rx_src[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  assign mem_rdata = uart_rs ? rdr : {tdre, rdrf, 6'b0};

  always #10 clk = ~clk;

  acia_host #(.TX_DEPTH(8), .RX_DEPTH(8), .CTRL_INIT(8'hC0)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .uart_cs   (uart_cs),
    .uart_rs   (uart_rs),
    .uart_en   (uart_en),
    .rd_pin    (rd_pin),
    .we_pin    (we_pin),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx_level  (tx_level),
    .rx_level  (rx_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: check, record this cycle's bus effects, advance one clock.
  task automatic cycle();
    bit do_wr;
    bit do_rd;
    bit cs_seen;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    cs_seen = uart_cs;
    if (sys_rst_n) begin
      chk("tx_level", 32'(tx_level), 32'(tx_q.size()));
      chk("rx_level", 32'(rx_level), 32'(rx_q.size()));
      chk("tx_ready", 32'(tx_ready), 32'(tx_q.size() < 8));
      chk("rx_valid", 32'(rx_valid), 32'(rx_q.size() != 0));
      if (rx_q.size() != 0) chk("rx_byte_head", 32'(rx_byte), 32'(rx_q[0]));
      if (rel_cycles >= 1) begin
        chk("cs_held", 32'(uart_cs), 32'd1);
        chk("rd_we_excl", 32'(rd_pin & we_pin), 32'd0);
        chk("en_only_data_wr", 32'(uart_en & ~(we_pin & uart_rs)), 32'd0);
        chk("data_wr_has_en", 32'(we_pin & uart_rs & ~uart_en), 32'd0);
        chk("wr_needs_tdre", 32'(we_pin & uart_rs & ~tdre), 32'd0);
        chk("rd_needs_rdrf", 32'(rd_pin & uart_rs & ~rdrf), 32'd0);
        chk("rs_idle", 32'(uart_rs & ~(rd_pin | we_pin)), 32'd0);
      end
      do_wr = we_pin && uart_rs && uart_en;
      do_rd = rd_pin && uart_rs;
      if (do_wr) begin
        if (tx_q.size() == 0) chk("tx_write_unexpected", 32'd1, 32'd0);
        else chk("tx_write_byte", 32'(mem_wdata), 32'(tx_q.pop_front()));
        n_wr++;
      end
      if (rx_valid && rx_ready && rx_q.size() != 0) begin
        chk("rx_pop_byte", 32'(rx_byte), 32'(rx_q.pop_front()));
        n_pop++;
      end
      if (do_rd) rx_q.push_back(rdr);
      if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
    end
    @(posedge clk);
    #1;
    if (sys_rst_n) rel_cycles++;
    else rel_cycles = 0;
    if (do_rd) rdrf = 1'b0;
    if (do_wr) begin
      tdre = 1'b0;
      tdre_wait = $urandom_range(tdre_max, 1);
    end else if (auto_tdre && !tdre) begin
      if (tdre_wait > 0) tdre_wait--;
      if (tdre_wait == 0) tdre = 1'b1;
    end
    if (auto_rx && cs_seen && !rdrf && rx_src.size() != 0) begin
      rdr  = rx_src.pop_front();
      rdrf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wait_write(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if (we_pin && uart_en) begin
        ok = 1'b1;
        d  = mem_wdata;
        break;
      end
      cycle();
    end
  endtask

  task automatic wait_init(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (we_pin) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk({tag, "_we_seen"}, 32'(found), 32'd1);
    chk({tag, "_rs"}, 32'(uart_rs), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'hC0);
    chk({tag, "_rd"}, 32'(rd_pin), 32'd0);
    chk({tag, "_en"}, 32'(uart_en), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"}, 32'(uart_cs), 32'd0);
    chk({tag, "_rs"}, 32'(uart_rs), 32'd0);
    chk({tag, "_en"}, 32'(uart_en), 32'd0);
    chk({tag, "_rd"}, 32'(rd_pin), 32'd0);
    chk({tag, "_we"}, 32'(we_pin), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_tx_level"}, 32'(tx_level), 32'd0);
    chk({tag, "_rx_level"}, 32'(rx_level), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    bit         ok;
    logic [7:0] fill [9];

    sys_rst_n = 1'b1;
    tx_valid = 1'b0; tx_byte = 8'h00; rx_ready = 1'b0;
    tdre = 1'b0; rdrf = 1'b0; rdr = 8'h00;
    auto_tdre = 1'b0; auto_rx = 1'b0; tdre_wait = 0; tdre_max = 3;
    rel_cycles = 0; n_wr = 0; n_pop = 0;
    #1 sys_rst_n = 1'b0;
    @(negedge clk);
    repeat (2) cycle();
    chk_reset_outputs("rst");

    // Control write first, then steady status polling.
    sys_rst_n = 1'b1;
    wait_init("init");
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("poll_rd", 32'(rd_pin), 32'd1);
      chk("poll_rs", 32'(uart_rs), 32'd0);
      cycle();
    end

    // Two TX bytes, second waits for TDRE to come back.
    tx_valid = 1'b1; tx_byte = 8'hA5; cycle();
    tx_byte = 8'h3C; cycle();
    tx_valid = 1'b0;
    chk("tx_level_2", 32'(tx_level), 32'd2);
    tdre = 1'b1; auto_tdre = 1'b1; tdre_max = 3;
    wait_write(d, ok);
    chk("txwr1_seen", 32'(ok), 32'd1);
    chk("txwr1_byte", 32'(d), 32'hA5);
    chk("txwr1_rs", 32'(uart_rs), 32'd1);
    chk("txwr1_rd", 32'(rd_pin), 32'd0);
    cycle();
    wait_write(d, ok);
    chk("txwr2_seen", 32'(ok), 32'd1);
    chk("txwr2_byte", 32'(d), 32'h3C);
    cycle();
    chk("tx_level_0", 32'(tx_level), 32'd0);

    // RX beats TX when both flags are up.
    auto_tdre = 1'b0;
    for (int i = 0; i < 6 && tdre; i++) cycle();
    tx_valid = 1'b1; tx_byte = 8'h99; cycle();
    tx_valid = 1'b0;
    tdre = 1'b1; rdrf = 1'b1; rdr = 8'h55;
    chk("prio_poll", 32'(rd_pin & ~uart_rs), 32'd1);
    cycle();
    chk("prio_rxrd", 32'(rd_pin & uart_rs), 32'd1);
    chk("prio_no_tx", 32'(we_pin | uart_en), 32'd0);
    cycle();
    chk("rx_valid_55", 32'(rx_valid), 32'd1);
    chk("rx_byte_55", 32'(rx_byte), 32'h55);
    chk("prio_poll_again", 32'(rd_pin & ~uart_rs), 32'd1);
    cycle();
    chk("prio_txwr", 32'(we_pin & uart_en), 32'd1);
    chk("prio_txwr_byte", 32'(mem_wdata), 32'h99);
    cycle();
    rx_ready = 1'b1; cycle(); rx_ready = 1'b0;
    chk("rx_empty_after_pop", 32'(rx_level), 32'd0);

    // Fill RX with one byte still pending in the ACIA.
    auto_rx = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fill[i] = 8'($urandom);
      rx_src.push_back(fill[i]);
    end
    for (int i = 0; i < 80 && rx_level != 4'd8; i++) cycle();
    chk("rx_full", 32'(rx_level), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("hold_no_rd", 32'(rd_pin), 32'd0);
      chk("hold_no_we", 32'(we_pin), 32'd0);
      cycle();
    end
    chk("hold_rdrf_pending", 32'(rdrf), 32'd1);
    chk("hold_head", 32'(rx_byte), 32'(fill[0]));
    rx_ready = 1'b1; cycle(); rx_ready = 1'b0;
    chk("hold_exit_poll", 32'(rd_pin & ~uart_rs), 32'd1);
    cycle();
    chk("hold_exit_rxrd", 32'(rd_pin & uart_rs), 32'd1);
    chk("hold_exit_byte", 32'(mem_rdata), 32'(fill[8]));
    cycle();
    chk("rx_full_again", 32'(rx_level), 32'd8);
    rx_ready = 1'b1;
    for (int i = 0; i < 20 && rx_level != 4'd0; i++) cycle();
    rx_ready = 1'b0;
    chk("rx_drained", 32'(rx_level), 32'd0);
    chk("rx_pop_count", 32'(n_pop), 32'd10);

    // Reset in the middle of a TX write.
    auto_rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_byte = 8'($urandom); cycle();
    end
    tx_valid = 1'b0;
    chk("pre_rst_level", 32'(tx_level), 32'd3);
    tdre = 1'b1;
    wait_write(d, ok);
    chk("mid_txwr_seen", 32'(ok), 32'd1);
    chk("mid_txwr_level", 32'(tx_level), 32'd3);
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tx_q.delete();
    rx_q.delete();
    @(negedge clk);
    repeat (2) cycle();
    sys_rst_n = 1'b1;
    wait_init("reinit");
    chk("reinit_tx_level", 32'(tx_level), 32'd0);
    cycle();

    // Random traffic both ways; order checked per byte by the queues.
    auto_tdre = 1'b1; auto_rx = 1'b1; tdre_max = 4;
    n_wr = 0; n_pop = 0;
    for (int i = 0; i < 800; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_byte  = 8'($urandom);
      rx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) rx_src.push_back(8'($urandom));
      cycle();
    end
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (tx_q.size() == 0 && rx_q.size() == 0 && rx_src.size() == 0 && !rdrf) break;
      cycle();
    end
    chk("drain_tx_level", 32'(tx_level), 32'd0);
    chk("drain_rx_level", 32'(rx_level), 32'd0);
    chk("drain_tx_model", 32'(tx_q.size()), 32'd0);
    chk("drain_rx_src", 32'(rx_src.size() + 32'(rdrf)), 32'd0);
    chk("random_tx_activity", 32'(n_wr > 50), 32'd1);
    chk("random_rx_activity", 32'(n_pop > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acia_host.md
ACIA_HOST -- requirements
Module: acia_host

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8: TX FIFO entries, power of two, 2..64.
REQ-002 SHALL have parameter RX_DEPTH, default 8: RX FIFO entries, power of two, 2..64.
REQ-003 SHALL have parameter CTRL_INIT, default 8'h00: byte written to the ACIA control register after reset (bit7 RX IRQ enable, bit6 TX IRQ enable).
REQ-004 SHALL have ports, in this order:
- clk  in  1  system clock (50 MHz); all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- tx_valid  in  1  user byte offered.
- tx_byte  in  8  user byte to transmit.
- tx_ready  out  1  TX FIFO not full.
- rx_valid  out  1  RX FIFO not empty.
- rx_byte  out  8  RX FIFO head, valid while rx_valid.
- rx_ready  in  1  user pops RX head.
- uart_cs  out  1  ACIA chip select.
- uart_rs  out  1  register select: 0 control/status, 1 data.
- uart_en  out  1  transmit start strobe.
- rd_pin  out  1  read strobe.
- we_pin  out  1  write strobe.
- mem_wdata  out  8  write data to ACIA.
- mem_rdata  in  8  combinational read data from ACIA (status: bit7 TDRE, bit6 RDRF).
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.

Function
REQ-005 SHALL act as the bus master of one MC6850-style ACIA: drain TX FIFO into ACIA, fill RX FIFO from ACIA.
REQ-006 SHALL push tx_byte into TX FIFO on each edge with tx_valid && tx_ready; SHALL pop RX FIFO on each edge with rx_valid && rx_ready; push and pop of the same FIFO in one cycle SHALL both take effect, level unchanged.
REQ-007 SHALL hold uart_cs=1 in every non-reset cycle (ACIA captures RX bytes only while selected).
REQ-008 SHALL implement FSM states INIT, POLL, RXRD, TXWR, HOLD; exactly one bus access per cycle.
REQ-009 INIT: drive uart_rs=0, we_pin=1, mem_wdata=CTRL_INIT for one cycle; next POLL.
REQ-010 POLL: drive uart_rs=0, rd_pin=1; sample mem_rdata same cycle; next RXRD if bit6=1, else TXWR if bit7=1 and TX FIFO not empty, else POLL.
REQ-011 POLL SHALL be entered only when RX FIFO has free space; if RX FIFO full, go to HOLD instead (all strobes 0) and remain until a pop frees space, then POLL. Rationale: a status read clears RDRF.
REQ-012 RXRD: drive uart_rs=1, rd_pin=1; push mem_rdata into RX FIFO same edge; next POLL (or HOLD if now full).
REQ-013 TXWR: drive uart_rs=1, we_pin=1, uart_en=1, mem_wdata=TX FIFO head; pop TX FIFO same edge; next POLL (or HOLD per REQ-011).
REQ-014 RX has priority over TX when both RDRF and TDRE are set; TX waits one extra POLL.
REQ-015 Strobes and mem_wdata SHALL be registered decode of the state (glitch-free); uart_en, we_pin, rd_pin never asserted together except as listed.
REQ-016 FIFO pointers SHALL wrap modulo depth; levels SHALL saturate by construction (no push when full, no pop when empty); user push into full TX FIFO is ignored (tx_ready=0).
REQ-017 Byte order SHALL be preserved end-to-end in both directions.

Reset
REQ-018 During sys_rst_n=0: uart_cs, uart_rs, uart_en, rd_pin, we_pin = 0; mem_wdata=8'h00; FIFOs empty; tx_ready=1; rx_valid=0; levels 0; state INIT.
REQ-019 Reset mid-operation SHALL discard all FIFO content immediately; first cycle after release SHALL be INIT.

Structure
REQ-020 Shared package SHALL hold FSM state encoding, status bit indices (TDRE=7, RDRF=6), and control bit indices.
REQ-021 One sub-module sync_fifo (parameter DEPTH, 8-bit data, level output) SHALL be instantiated twice.

Verification
REQ-022 Reset release, CTRL_INIT=8'hC0 -> first cycle we_pin=1, uart_rs=0, mem_wdata=8'hC0; then continuous POLL reads.
REQ-023 Push 8'hA5, 8'h3C with TDRE=1 -> TXWR writes 8'hA5 with uart_en=1, waits for TDRE re-set, then writes 8'h3C; tx_level 2->0.
REQ-024 Model returns status 8'hC0 then data 8'h55 -> RXRD follows POLL immediately, rx_byte=8'h55, rx_valid=1, no TXWR that cycle.
REQ-025 Fill RX FIFO (8 bytes, rx_ready=0) with RDRF pending -> HOLD, zero rd_pin; one pop -> POLL then RXRD captures pending byte.
REQ-026 Assert sys_rst_n=0 with tx_level=3 mid-TXWR -> strobes 0 at once, levels 0, INIT after release.
